// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Takes parallel words over a valid/ready handshake and shifts them out one
//   bit per clock. A single holding register lets the next word queue up while
//   the current one is still shifting, so back-to-back words leave no idle
//   cycle on the serial side.
//
// Parameters
//   WIDTH      bits per word (>= 1)
//   MSB_FIRST  1: in_data[WIDTH-1] leaves first, 0: in_data[0] leaves first
//   IDLE_BIT   level on out_bit whenever no payload bit is being sent
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_data    in   word to serialize, captured on an accepted handshake
//   in_valid   in   upstream offers in_data
//   in_ready   out  a word can be taken this cycle (registers only)
//   out_bit    out  serial bit stream
//   out_valid  out  out_bit carries a payload bit this cycle
//   word_done  out  last bit of a word is on out_bit this cycle
//   busy       out  shifter or holding register occupied
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Bit of a word that goes out first, given the configured bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      head_bit = word[WIDTH-1];
    end else begin
      head_bit = word[0];
    end
  endfunction

  // Word after its leading bit has been consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      advance = word << 1'b1;
    end else begin
      advance = word >> 1'b1;
    end
  endfunction

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [WIDTH-1:0]   r_hold;
  logic               r_hold_full;
  logic               r_in_ready;
  logic               r_out_bit;
  logic               r_out_valid;
  logic               r_word_done;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic [CNT_W-1:0]   w_bitcnt_nxt;
  logic [WIDTH-1:0]   w_hold_nxt;
  logic               w_hold_full_nxt;
  logic               w_accept;
  logic               w_last;

  // in_ready comes from a flop, so the handshake has no in_valid -> in_ready path.
  assign w_accept = in_valid && r_in_ready;
  assign w_last   = (r_bitcnt == LAST_CNT);

  // Next-state logic: word loading, shifting, hand-over from the holding register.
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_bitcnt_nxt    = r_bitcnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt  = in_data;
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_SHIFT;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          if (r_hold_full) begin
            // Held word takes over; a same-edge accept refills the hold slot.
            w_shreg_nxt  = r_hold;
            w_bitcnt_nxt = '0;
            if (w_accept) begin
              w_hold_nxt      = in_data;
              w_hold_full_nxt = 1'b1;
            end else begin
              w_hold_full_nxt = 1'b0;
            end
          end else if (w_accept) begin
            // Nothing held: a word arriving on the closing edge goes straight in.
            w_shreg_nxt  = in_data;
            w_bitcnt_nxt = '0;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_shreg_nxt  = advance(r_shreg);
          w_bitcnt_nxt = r_bitcnt + CNT_ONE;
          if (w_accept) begin
            w_hold_nxt      = in_data;
            w_hold_full_nxt = 1'b1;
          end else begin
            w_hold_full_nxt = r_hold_full;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_hold_full_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; outputs are computed from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_bit   <= IDLE_BIT;
      r_out_valid <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_in_ready  <= !w_hold_full_nxt;
      r_out_valid <= (w_state_nxt == S_SHIFT);
      r_out_bit   <= (w_state_nxt == S_SHIFT) ? head_bit(w_shreg_nxt) : IDLE_BIT;
      r_word_done <= (w_state_nxt == S_SHIFT) && (w_bitcnt_nxt == LAST_CNT);
      r_busy      <= (w_state_nxt == S_SHIFT) || w_hold_full_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign word_done = r_word_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Two instances: u_msb (WIDTH=10, MSB first) and u_lsb (WIDTH=8, LSB first).
//   A queue-of-bits model predicts every output each cycle; directed tests add
//   literal expectations for bit sequences, streaming and reset behaviour.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] din0  = 10'h000;
  logic [7:0] din1  = 8'h00;
  logic [1:0] vin   = 2'b00;
  logic [1:0] rdy, ob, ov, wd, bz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(10), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(din0), .in_valid(vin[0]),
    .in_ready(rdy[0]), .out_bit(ob[0]), .out_valid(ov[0]),
    .word_done(wd[0]), .busy(bz[0])
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(din1), .in_valid(vin[1]),
    .in_ready(rdy[1]), .out_bit(ob[1]), .out_valid(ov[1]),
    .word_done(wd[1]), .busy(bz[1])
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: each instance holds a queue of bits still to be sent. The front
  // bit is on out_bit; more than one word's worth queued means the hold slot
  // is full, which is exactly when in_ready must be low.
  bit         q0[$];
  bit         q1[$];
  logic [1:0] m_rdy = 2'b00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      m_rdy <= 2'b00;
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (vin[0] && m_rdy[0]) for (int b = 9; b >= 0; b--) q0.push_back(din0[b]);
      if (q1.size() > 0) void'(q1.pop_front());
      if (vin[1] && m_rdy[1]) for (int b = 0; b < 8; b++) q1.push_back(din1[b]);
      m_rdy[0] <= (q0.size() <= 10);
      m_rdy[1] <= (q1.size() <= 8);
    end
  end

  task automatic cmp(input int i, input int sz, input bit head, input int w);
    logic [4:0] got;
    logic [4:0] exp;
    bit ev;
    ev  = (sz > 0);
    got = {rdy[i], ob[i], ov[i], wd[i], bz[i]};
    exp = {m_rdy[i], ev ? head : 1'b0, ev, ev && (((sz - 1) % w) == 0), ev};
    check($sformatf("model_inst%0d {rdy,bit,valid,done,busy}", i), {27'd0, got}, {27'd0, exp});
  endtask

  // Compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    cmp(0, q0.size(), (q0.size() > 0) ? q0[0] : 1'b0, 10);
    cmp(1, q1.size(), (q1.size() > 0) ? q1[0] : 1'b0, 8);
  end

  // Recorder for the streaming test on u_msb.
  bit rec = 1'b0;
  bit logq[$];
  int cyc, first, last, wdc;
  always @(negedge clk) begin
    if (!rec) begin
      logq.delete();
      cyc   <= 0;
      first <= -1;
      last  <= -1;
      wdc   <= 0;
    end else begin
      cyc <= cyc + 1;
      if (ov[0]) begin
        logq.push_back(ob[0]);
        if (first < 0) first <= cyc;
        last <= cyc;
      end
      if (wd[0]) wdc <= wdc + 1;
    end
  end

  logic [9:0] wl[3];

  // Offer one word to u_msb; returns just after the accepting edge.
  task automatic offer0(input logic [9:0] d);
    bit acc;
    acc = 1'b0;
    din0 = d;
    vin[0] = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = rdy[0];
      @(posedge clk); #1;
    end
    vin[0] = 1'b0;
    if (!acc) check("offer0_timeout", 32'd0, 32'd1);
  endtask

  // Hold in_valid high and feed wl[0..n-1] as each one is accepted.
  task automatic stream0(input int n);
    int  idx;
    bit  acc;
    idx = 0;
    din0 = wl[0];
    vin[0] = 1'b1;
    for (int k = 0; k < 200 && idx < n; k++) begin
      @(negedge clk);
      acc = rdy[0];
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < n) din0 = wl[idx];
      end
    end
    vin[0] = 1'b0;
    if (idx < n) check("stream0_timeout", 32'd0, 32'd1);
  endtask

  // Expect the 10 bits of e MSB first on u_msb, then one idle cycle.
  task automatic expect_bits0(input string nm, input logic [9:0] e);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("%s_bit%0d {valid,bit,done}", nm, k + 1),
            {29'd0, ov[0], ob[0], wd[0]}, {29'd0, 1'b1, e[9 - k], (k == 9)});
    end
    @(negedge clk);
    check($sformatf("%s_idle_after {valid,bit}", nm), {30'd0, ov[0], ob[0]}, 32'd0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (bz == 2'b00);
    end
    if (!done) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [29:0] got30;
    logic [29:0] exp30;

    // 1: reset held low with in_valid high on both instances.
    #1 reset = 1'b0;
    din0 = 10'h3FF;
    din1 = 8'hFF;
    vin  = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t1_reset {rdy,valid,bit} x2", {26'd0, rdy, ov, ob}, 32'd0);
    end
    @(posedge clk); #1;
    vin   = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    check("t1_ready_low_before_edge", {30'd0, rdy}, 32'd0);
    @(negedge clk);
    check("t1_ready_after_release", {30'd0, rdy}, 32'd3);
    check("t1_nothing_accepted_busy", {30'd0, bz}, 32'd0);
    @(posedge clk); #1;

    // 2: single word, MSB first.
    offer0(10'b0010010010);
    expect_bits0("t2", 10'b0010010010);

    // 3: three words streamed with in_valid held high.
    @(posedge clk); #1;
    rec   = 1'b1;
    wl[0] = 10'h092;
    wl[1] = 10'h3FF;
    wl[2] = 10'h000;
    stream0(3);
    wait_idle();
    @(posedge clk); #1;
    got30 = 30'd0;
    for (int j = 0; j < 30 && j < logq.size(); j++) got30 = {got30[28:0], logq[j]};
    exp30 = 30'b0010010010_1111111111_0000000000;
    check("t3_valid_count", logq.size(), 32'd30);
    check("t3_bits", {2'd0, got30}, {2'd0, exp30});
    check("t3_contiguous", last - first + 1, 32'd30);
    check("t3_word_done_pulses", wdc, 32'd3);
    rec = 1'b0;

    // 4: LSB-first instance, word 0x01.
    din1   = 8'h01;
    vin[1] = 1'b1;
    begin
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge clk);
        acc = rdy[1];
        @(posedge clk); #1;
      end
      vin[1] = 1'b0;
      if (!acc) check("t4_accept_timeout", 32'd0, 32'd1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t4_bit%0d {valid,bit,done}", k + 1),
            {29'd0, ov[1], ob[1], wd[1]}, {29'd0, 1'b1, (k == 0), (k == 7)});
    end
    @(negedge clk);
    check("t4_idle_after {valid,bit}", {30'd0, ov[1], ob[1]}, 32'd0);
    @(posedge clk); #1;

    // 5: reset after the 4th bit with a held word pending.
    wl[0] = 10'h2AA;
    wl[1] = 10'h0F0;
    stream0(2);
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("t5_pending {valid,rdy,busy}", {29'd0, ov[0], rdy[0], bz[0]}, 32'd5);
    #2 reset = 1'b0;
    #1;
    check("t5_in_reset {valid,done,busy,rdy}", {28'd0, ov[0], wd[0], bz[0], rdy[0]}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    offer0(10'h155);
    expect_bits0("t5_after", 10'h155);

    // 6: second word offered three cycles after the first finishes.
    @(posedge clk); #1;
    offer0(10'h3C5);
    expect_bits0("t6_first", 10'h3C5);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_gap2 {valid,bit}", {30'd0, ov[0], ob[0]}, 32'd0);
    @(posedge clk); #1;
    din0   = 10'h201;
    vin[0] = 1'b1;
    @(negedge clk);
    check("t6_gap3 {valid,bit,rdy}", {29'd0, ov[0], ob[0], rdy[0]}, 32'd1);
    @(posedge clk); #1;
    vin[0] = 1'b0;
    @(negedge clk);
    check("t6_second_start {valid,bit}", {30'd0, ov[0], ob[0]}, 32'd3);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
